mem_access_unit: RTL

- Parametrised multi-cycle memory access sequencer.
- Replaces the hard-wired MAR/MDR/R_W/MOV/MOC sequencing in control_unit with one reusable block.
- Accepts a single load/store request from the control unit and drives the RAM with the MOV/MOC handshake.
- Handles byte, halfword and word sizes: lane steering, sign extension, alignment checking and timeout.

---
 rtl/mem_access_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store sequencer driving a RAM over the MOV/MOC handshake.
// Optional build macro MAU_BIG_ENDIAN_EN selects big-endian byte-lane mapping (default little-endian).
`default_nettype none

module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              R_W,
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_rw,
  output logic              MOV,
  input  logic              Moc,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic                rw_q, rw_d;
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          err_code_q, err_code_d;

  logic [3:0]          be;
  logic [1:0]          lane;
  logic [DATA_W-1:0]   rd_shift;
  logic [DATA_W-1:0]   load_val;
  logic [1:0]          chk_code;

  // lane = index of the lowest enabled byte lane; both data shifts key off it
  always_comb begin
    be   = 4'b1111;
    lane = 2'd0;
    case (size_q)
`ifdef MAU_BIG_ENDIAN_EN
      2'b00: begin be = 4'b1000 >> addr_q[1:0]; lane = 2'd3 - addr_q[1:0]; end
      2'b01: begin be = 4'b1100 >> addr_q[1:0]; lane = 2'd2 - addr_q[1:0]; end
`else
      2'b00: begin be = 4'b0001 << addr_q[1:0]; lane = addr_q[1:0]; end
      2'b01: begin be = 4'b0011 << addr_q[1:0]; lane = addr_q[1:0]; end
`endif
      default: begin be = 4'b1111; lane = 2'd0; end
    endcase
  end

  always_comb begin
    rd_shift = mem_rdata >> {lane, 3'b000};
    case (size_q)
      2'b00:   load_val = {{(DATA_W-8){sgn_q & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = {{(DATA_W-16){sgn_q & rd_shift[15]}}, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
  end

  always_comb begin
    chk_code = 2'b00;
    if (size == 2'b11)                           chk_code = 2'b11;
    else if (size == 2'b01 && addr[0])           chk_code = 2'b01;
    else if (size == 2'b10 && addr[1:0] != 2'b00) chk_code = 2'b01;
  end

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          rw_d       = R_W;
          size_d     = size;
          sgn_d      = sgn;
          addr_d     = addr;
          wdata_d    = wdata;
          err_code_d = chk_code;
          state_d    = (chk_code != 2'b00) ? S_ERROR : S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = 8'd0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (Moc) begin
          if (rw_q) rdata_d = load_val;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == TO_CNT) begin
            err_code_d = 2'b10;
            state_d    = S_ERROR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      rw_q       <= 1'b0;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= 8'd0;
      rdata_q    <= '0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_code_q <= err_code_d;
    end
  end

  // state decodes keep MOV/busy/mem_be combinational so async reset drops them at once
  assign busy      = (state_q != S_IDLE);
  assign MOV       = (state_q == S_ACCESS);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERROR);
  assign mem_be    = (state_q == S_SETUP || state_q == S_ACCESS) ? be : 4'b0000;
  assign mem_rw    = rw_q;
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = wdata_q << {lane, 3'b000};
  assign rdata     = rdata_q;
  assign err_code  = err_code_q;

endmodule

`default_nettype wire
